denoise_pixel_packer: RTL and testbench

DENOISE_PIXEL_PACKER -- requirements
Module: denoise_pixel_packer

---
 rtl/denoise_pkg.sv | 20 ++
 rtl/denoise_word_fifo.sv | 57 +++++
 rtl/denoise_pixel_packer.sv | 128 ++++++++++++
 tb/tb_denoise_pixel_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared types and constants for the denoise pixel packer.
package denoise_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int WORD_BITS    = 8 * PIX_PER_WORD;

  // 34-bit FIFO entry: packed pixels plus line/frame markers.
  typedef struct packed {
    logic [WORD_BITS-1:0] data;
    logic                 last;
    logic                 user;
  } word_t;

endpackage

// File: rtl/denoise_word_fifo.sv
// Word FIFO for the packer; head entry is visible combinationally and reads as zero when empty.
module denoise_word_fifo
  import denoise_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  word_t wr_data,
  input  logic  rd_en,
  output word_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign rd_ok = rd_en && !empty;
  // A write into a full FIFO is only safe when the head leaves on the same edge.
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/denoise_pixel_packer.sv
// Packs filtered 8-bit pixels into 32-bit AXI-Stream words with line/frame markers,
// dropping words (sticky overflow) when the output FIFO cannot accept them.
module denoise_pixel_packer
  import denoise_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        frame_begin,
  input  logic        denoise_valid,
  input  logic [7:0]  denoise_dout,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic        frame_done
);

  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [9:0]    PIX_LAST  = 10'(LINE_PIXELS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);

  state_t        state_reg;
  logic [1:0]    byte_idx_reg;
  logic [9:0]    pix_cnt_reg;
  logic [LW-1:0] line_cnt_reg;
  logic [23:0]   acc_reg;
  word_t         word_reg;
  logic          word_valid_reg;
  logic          overflow_reg;
  logic          frame_done_reg;

  word_t fifo_head;
  logic  fifo_full;
  logic  fifo_empty;
  logic  fifo_rd;
  logic  word_drop;

  assign fifo_rd   = !fifo_empty && m_axis_tready;
  assign word_drop = word_valid_reg && fifo_full && !fifo_rd;

  denoise_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .wr_en   (word_valid_reg),
    .wr_data (word_reg),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head.data;
  assign m_axis_tlast  = fifo_head.last;
  assign m_axis_tuser  = fifo_head.user;
  assign overflow      = overflow_reg;
  assign frame_done    = frame_done_reg;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_reg      <= ST_IDLE;
      byte_idx_reg   <= '0;
      pix_cnt_reg    <= '0;
      line_cnt_reg   <= '0;
      acc_reg        <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;

      if (word_drop)           overflow_reg <= 1'b1;
      else if (clear_overflow) overflow_reg <= 1'b0;

      if (frame_begin) begin
        // A pixel arriving with frame_begin is pixel 0 of the new frame.
        state_reg    <= ST_ACTIVE;
        line_cnt_reg <= '0;
        if (denoise_valid) begin
          acc_reg[7:0] <= denoise_dout;
          byte_idx_reg <= 2'd1;
          pix_cnt_reg  <= 10'd1;
        end else begin
          byte_idx_reg <= 2'd0;
          pix_cnt_reg  <= '0;
        end
      end else if (state_reg == ST_ACTIVE && denoise_valid) begin
        unique case (byte_idx_reg)
          2'd0: acc_reg[7:0]   <= denoise_dout;
          2'd1: acc_reg[15:8]  <= denoise_dout;
          2'd2: acc_reg[23:16] <= denoise_dout;
          2'd3: begin
            word_reg.data  <= {denoise_dout, acc_reg};
            word_reg.last  <= (pix_cnt_reg == PIX_LAST);
            word_reg.user  <= (line_cnt_reg == '0) && (pix_cnt_reg == 10'd3);
            word_valid_reg <= 1'b1;
          end
        endcase
        byte_idx_reg <= byte_idx_reg + 1'b1;

        if (pix_cnt_reg == PIX_LAST) begin
          pix_cnt_reg <= '0;
          if (line_cnt_reg == LINE_LAST) begin
            line_cnt_reg   <= '0;
            state_reg      <= ST_DONE;
            frame_done_reg <= 1'b1;
          end else begin
            line_cnt_reg <= line_cnt_reg + 1'b1;
          end
        end else begin
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_denoise_pixel_packer.sv
// Randomized and directed bench for denoise_pixel_packer against a frame-position model.
module tb_denoise_pixel_packer;

  localparam int LP = 8;
  localparam int FL = 2;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic        denoise_valid = 1'b0;
  logic [7:0]  denoise_dout = 8'h00;
  logic        m_axis_tready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        overflow;
  logic        frame_done;

  always #5 clk = ~clk;

  denoise_pixel_packer #(
    .LINE_PIXELS (LP),
    .FRAME_LINES (FL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .frame_begin    (frame_begin),
    .denoise_valid  (denoise_valid),
    .denoise_dout   (denoise_dout),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .frame_done     (frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } mw_t;

  // Model: frame position counts pixels since frame_begin; words form every 4 pixels.
  mw_t        mfifo[$];
  mw_t        pend;
  bit         pend_v = 0;
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_buf[4];
  int         m_nb = 0;
  bit         m_ovf = 0;
  bit         m_fd = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit rd;
    bit room;
    if (!rst_n) begin
      mfifo.delete();
      pend_v = 0; m_active = 0; m_pos = 0; m_nb = 0; m_ovf = 0; m_fd = 0;
    end else begin
      rd   = (mfifo.size() > 0) && m_axis_tready;
      room = (mfifo.size() < FD) || rd;
      if (rd) void'(mfifo.pop_front());
      if (pend_v && !room) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      if (pend_v && room) mfifo.push_back(pend);
      pend_v = 0;
      m_fd = 0;
      if (frame_begin) begin
        m_active = 1; m_pos = 0; m_nb = 0;
      end
      if (denoise_valid && m_active) begin
        m_buf[m_nb] = denoise_dout;
        m_nb++;
        if (m_nb == 4) begin
          pend.d = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          pend.l = ((m_pos % LP) == LP - 1);
          pend.u = (m_pos == 3);
          pend_v = 1;
          m_nb = 0;
        end
        m_pos++;
        if (m_pos == LP * FL) begin
          m_active = 0;
          m_fd = 1;
        end
      end
    end
  end

  int fd_cnt = 0;

  always @(negedge clk) begin
    check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, mfifo.size() > 0});
    if (mfifo.size() > 0) begin
      check("tdata", m_axis_tdata, mfifo[0].d);
      check("tlast", {31'd0, m_axis_tlast}, {31'd0, mfifo[0].l});
      check("tuser", {31'd0, m_axis_tuser}, {31'd0, mfifo[0].u});
    end
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    if (frame_done) fd_cnt++;
  end

  mw_t xlog[$];

  always @(posedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      xlog.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
      $display("xfer data=0x%08h last=%0b user=%0b t=%0t", m_axis_tdata, m_axis_tlast, m_axis_tuser, $time);
    end
  end

  task automatic pix(input logic fb, input logic [7:0] v);
    @(posedge clk); #1;
    frame_begin = fb; denoise_valid = 1'b1; denoise_dout = v;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      frame_begin = 1'b0; denoise_valid = 1'b0;
    end
  endtask

  task automatic fb_only();
    @(posedge clk); #1;
    frame_begin = 1'b1; denoise_valid = 1'b0;
  endtask

  initial begin
    int thr;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Basic packing and output latency.
    fb_only();
    pix(1'b0, 8'h01); pix(1'b0, 8'h02); pix(1'b0, 8'h03); pix(1'b0, 8'h04);
    @(negedge clk);
    check("lat_c0", {31'd0, m_axis_tvalid}, 32'd0);
    idle_cyc(1);
    @(negedge clk);
    check("lat_c1", {31'd0, m_axis_tvalid}, 32'd0);
    @(negedge clk);
    check("lat_c2", {31'd0, m_axis_tvalid}, 32'd1);
    check("pack_data", m_axis_tdata, 32'h04030201);
    check("pack_tuser", {31'd0, m_axis_tuser}, 32'd1);
    check("pack_tlast", {31'd0, m_axis_tlast}, 32'd0);
    idle_cyc(4);

    // Full frame: line ends and frame_done.
    xlog.delete(); fd_cnt = 0;
    fb_only();
    for (int i = 0; i < 16; i++) pix(1'b0, 8'(8'h10 + i));
    idle_cyc(6);
    check("line_words", xlog.size(), 32'd4);
    if (xlog.size() == 4) begin
      check("line_w0_data", xlog[0].d, 32'h13121110);
      check("line_tlast", {28'd0, xlog[3].l, xlog[2].l, xlog[1].l, xlog[0].l}, 32'b1010);
      check("line_tuser", {28'd0, xlog[3].u, xlog[2].u, xlog[1].u, xlog[0].u}, 32'b0001);
    end
    check("frame_done_cnt", fd_cnt, 32'd1);

    // Backpressure: 40 words into a blocked 8-deep FIFO.
    @(posedge clk); #1 m_axis_tready = 1'b0;
    for (int f = 0; f < 10; f++)
      for (int p = 0; p < 16; p++) pix(p == 0, 8'(f * 16 + p));
    idle_cyc(4);
    @(negedge clk);
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    check("bp_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("bp_head", m_axis_tdata, 32'h03020100);
    check("bp_tuser", {31'd0, m_axis_tuser}, 32'd1);
    @(posedge clk); #1 clear_overflow = 1'b1;
    @(posedge clk); #1 clear_overflow = 1'b0;
    @(negedge clk);
    check("bp_cleared", {31'd0, overflow}, 32'd0);
    xlog.delete();
    @(posedge clk); #1 m_axis_tready = 1'b1;
    idle_cyc(12);
    check("bp_words", xlog.size(), 32'd8);
    if (xlog.size() == 8) check("bp_w7_data", xlog[7].d, 32'h1F1E1D1C);

    // Mid-line frame_begin discards the partial word.
    xlog.delete();
    fb_only();
    for (int i = 0; i < 6; i++) pix(1'b0, 8'(8'hA0 + i));
    fb_only();
    for (int i = 0; i < 4; i++) pix(1'b0, 8'(8'hB0 + i));
    idle_cyc(6);
    check("mid_words", xlog.size(), 32'd2);
    if (xlog.size() == 2) begin
      check("mid_w0", xlog[0].d, 32'hA3A2A1A0);
      check("mid_w1", xlog[1].d, 32'hB3B2B1B0);
      check("mid_w1_tuser", {31'd0, xlog[1].u}, 32'd1);
    end

    // Reset in the middle of an active frame.
    @(posedge clk); #1 m_axis_tready = 1'b0;
    fb_only();
    for (int i = 0; i < 4; i++) pix(1'b0, 8'(8'hC0 + i));
    idle_cyc(3);
    @(negedge clk);
    check("prerst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_now_tdata", m_axis_tdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    xlog.delete();
    for (int i = 0; i < 8; i++) pix(1'b0, 8'(8'hD0 + i));
    idle_cyc(6);
    check("postrst_words", xlog.size(), 32'd0);

    // Randomized traffic with varying downstream readiness.
    for (int seg = 0; seg < 6; seg++) begin
      thr = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 3 : 4);
      for (int c = 0; c < 500; c++) begin
        @(posedge clk); #1;
        frame_begin    = ($urandom % 40) == 0;
        denoise_valid  = ($urandom % 4) != 0;
        denoise_dout   = 8'($urandom);
        m_axis_tready  = ($urandom % 4) < thr;
        clear_overflow = ($urandom % 64) == 0;
      end
    end
    @(posedge clk); #1;
    frame_begin = 1'b0; denoise_valid = 1'b0; clear_overflow = 1'b0; m_axis_tready = 1'b1;
    idle_cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
